// File: rtl/fir_mac_sequencer.sv
// Frame-synchronised control sequencer for a time-multiplexed FIR datapath:
// one delay-line shift, N_TAPS multiply-accumulate cycles, then an output load.
module fir_mac_sequencer #(
  parameter int unsigned N_TAPS = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              overrun_clr,
  output logic              shift_en,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_load,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic                shift_en_q, shift_en_d;
  logic [ADDR_W-1:0]   tap_addr_q, tap_addr_d;
  logic                acc_clr_q,  acc_clr_d;
  logic                acc_en_q,   acc_en_d;
  logic                out_load_q, out_load_d;
  logic                busy_q,     busy_d;
  logic                overrun_q,  overrun_d;

  // Outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    state_d    = state_q;
    shift_en_d = 1'b0;
    tap_addr_d = '0;
    acc_clr_d  = 1'b0;
    acc_en_d   = 1'b0;
    out_load_d = 1'b0;
    busy_d     = 1'b0;
    // A new overrun event in the same cycle as a clear keeps the flag set.
    overrun_d  = (overrun_q & ~overrun_clr) | (sample_valid & (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (sample_valid && enable) begin
          state_d    = ST_SHIFT;
          shift_en_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        state_d    = ST_MAC;
        acc_en_d   = 1'b1;
        acc_clr_d  = 1'b1;
        busy_d     = 1'b1;
      end
      ST_MAC: begin
        busy_d = 1'b1;
        if (tap_addr_q == LAST_TAP) begin
          state_d    = ST_DONE;
          out_load_d = 1'b1;
        end else begin
          acc_en_d   = 1'b1;
          tap_addr_d = tap_addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_en_q <= 1'b0;
      tap_addr_q <= '0;
      acc_clr_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      out_load_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_en_q <= shift_en_d;
      tap_addr_q <= tap_addr_d;
      acc_clr_q  <= acc_clr_d;
      acc_en_q   <= acc_en_d;
      out_load_q <= out_load_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign shift_en = shift_en_q;
  assign tap_addr = tap_addr_q;
  assign acc_clr  = acc_clr_q;
  assign acc_en   = acc_en_q;
  assign out_load = out_load_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized and directed bench for fir_mac_sequencer against a
// frame-position reference model (cycles elapsed since sample acceptance).
module tb_fir_mac_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          sample_valid;
  logic          overrun_clr;
  logic          shift_en;
  logic [AW-1:0] tap_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_load;
  logic          busy;
  logic          overrun;

  fir_mac_sequencer #(.N_TAPS(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .overrun_clr  (overrun_clr),
    .shift_en     (shift_en),
    .tap_addr     (tap_addr),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .out_load     (out_load),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int unsigned pos   = 0;   // 0 = idle, k = k-th cycle of the frame (1..N+2)
  bit          m_ovr = 1'b0;
  int          model_loads = 0;
  int          dut_loads   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: one frame occupies positions 1..N+2 after the accepting edge.
  task automatic model_edge();
    if (!reset) begin
      pos   = 0;
      m_ovr = 1'b0;
    end else begin
      m_ovr = (m_ovr && !overrun_clr) || (sample_valid && pos != 0);
      if (pos == 0) begin
        if (sample_valid && enable) pos = 1;
      end else if (pos == N + 2) begin
        pos = 0;
      end else begin
        pos = pos + 1;
      end
    end
    if (pos == N + 2) model_loads++;
  endtask

  task automatic compare_outputs();
    bit          in_mac;
    int unsigned exp_tap;
    in_mac  = (pos >= 2) && (pos <= N + 1);
    exp_tap = in_mac ? pos - 2 : 0;
    check("shift_en", 32'(shift_en), 32'(pos == 1));
    check("acc_en",   32'(acc_en),   32'(in_mac));
    check("acc_clr",  32'(acc_clr),  32'(pos == 2));
    check("out_load", 32'(out_load), 32'(pos == N + 2));
    check("busy",     32'(busy),     32'((pos >= 1) && (pos <= N + 2)));
    check("tap_addr", 32'(tap_addr), exp_tap);
    check("overrun",  32'(overrun),  32'(m_ovr));
    check("strobe_onehot", 32'($countones({shift_en, acc_en, out_load}) <= 1), 32'd1);
    check("acc_clr_implies_en", 32'(!acc_clr || acc_en), 32'd1);
    check("tap_range", 32'(32'(tap_addr) < N), 32'd1);
    if (out_load) dut_loads++;
  endtask

  // Drive inputs at negedge, let the DUT and model take the edge, compare 1 time unit later.
  task automatic step(input logic sv, input logic en, input logic clr, input logic rst_n);
    sample_valid = sv;
    enable       = en;
    overrun_clr  = clr;
    reset        = rst_n;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 1'b1);
  endtask

  initial begin
    sample_valid = 1'b0;
    enable       = 1'b1;
    overrun_clr  = 1'b0;
    reset        = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Single frame
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);

    // Back-to-back at minimum period
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);

    // One cycle too early: lands in DONE, must raise overrun only
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Clear racing a new overrun during MAC: set wins, lone clear then clears
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(10, 1'b1);

    // Enable gating
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    idle(8, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-frame at tap 4, then a full normal frame
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 199) != 0));
    end
    idle(12, 1'b1);

    check("out_load_count", 32'(dut_loads), 32'(model_loads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
